// File: rtl/branch_pkg.sv
// Shared types for the branch resolve slice: the per-fetch prediction tag
// and the resolver FSM state.
package branch_pkg;

   localparam int BR_PC_WIDTH = 32;

   typedef struct packed {
      logic                   valid;
      logic [BR_PC_WIDTH-1:0] pc;
      logic                   pred;
   } br_tag_t;

   typedef enum logic {BR_IDLE, BR_FLUSH} br_state_e;

endpackage

// File: rtl/bru_tag_pipe.sv
// Two-stage IF/ID -> ID/EX carrier for the {valid, pc, pred} fetch tag.
// Flush clears both valid bits and takes priority over stall.
module bru_tag_pipe
   import branch_pkg::*;
(
   input  logic    clk,
   input  logic    reset,
   input  logic    i_stall,
   input  logic    i_flush,
   input  br_tag_t i_if_tag,
   output br_tag_t o_ex_tag
);

   br_tag_t r_id_tag;
   br_tag_t r_ex_tag;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_id_tag <= '0;
         r_ex_tag <= '0;
      end else if (i_flush) begin
         // Squashed fetches keep their pc/pred but can never resolve.
         r_id_tag.valid <= 1'b0;
         r_ex_tag.valid <= 1'b0;
      end else if (!i_stall) begin
         r_id_tag <= i_if_tag;
         r_ex_tag <= r_id_tag;
      end
   end

   assign o_ex_tag = r_ex_tag;

endmodule

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolver: checks the carried prediction against the real
// outcome, trains the predictor, redirects fetch and flushes on a mispredict.
module branch_resolve_unit
   import branch_pkg::*;
#(
   parameter int PC_WIDTH     = 32,
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_WIDTH    = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 if_valid,
   input  logic [PC_WIDTH-1:0]  if_pc,
   input  logic                 if_pred_taken,
   input  logic                 stall,
   input  logic                 ex_br_valid,
   input  logic                 ex_br_taken,
   input  logic [PC_WIDTH-1:0]  ex_br_target,
   output logic                 update_en,
   output logic [PC_WIDTH-1:0]  ex_pc,
   output logic                 actual_taken,
   output logic                 redirect_valid,
   output logic [PC_WIDTH-1:0]  redirect_pc,
   output logic                 flush,
   output logic [CNT_WIDTH-1:0] branch_cnt,
   output logic [CNT_WIDTH-1:0] mispred_cnt
);

   localparam int FC_W = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);

   br_tag_t             w_if_tag;
   br_tag_t             w_ex_tag;
   br_state_e           r_state;
   br_state_e           w_state_next;
   logic [FC_W-1:0]     r_fcnt;
   logic [FC_W-1:0]     w_fcnt_next;
   logic                w_resolve;
   logic                w_mispred;
   logic                w_flush;
   logic [PC_WIDTH-1:0] w_seq_pc;
   logic [CNT_WIDTH-1:0] r_branch_cnt;
   logic [CNT_WIDTH-1:0] r_mispred_cnt;

   assign w_if_tag = {if_valid, if_pc, if_pred_taken};

   bru_tag_pipe u_tag_pipe (
      .clk      (clk),
      .reset    (reset),
      .i_stall  (stall),
      .i_flush  (w_flush),
      .i_if_tag (w_if_tag),
      .o_ex_tag (w_ex_tag)
   );

   // Stall gating keeps a held branch from training the predictor twice.
   assign w_resolve = ex_br_valid & w_ex_tag.valid & ~stall & (r_state == BR_IDLE);
   assign w_mispred = w_resolve & (w_ex_tag.pred != ex_br_taken);
   assign w_flush   = w_mispred | (r_state == BR_FLUSH);
   assign w_seq_pc  = w_ex_tag.pc + PC_WIDTH'(4);

   assign update_en      = w_resolve;
   assign ex_pc          = w_ex_tag.pc;
   assign actual_taken   = ex_br_taken;
   assign redirect_valid = w_mispred;
   // Zero when idle so the front end never sees a stale fall-through PC.
   assign redirect_pc    = w_mispred ? (ex_br_taken ? ex_br_target : w_seq_pc) : '0;
   assign flush          = w_flush;
   assign branch_cnt     = r_branch_cnt;
   assign mispred_cnt    = r_mispred_cnt;

   always_comb begin
      w_state_next = r_state;
      w_fcnt_next  = r_fcnt;
      case (r_state)
         BR_IDLE: begin
            if (w_mispred) begin
               w_state_next = BR_FLUSH;
               w_fcnt_next  = FC_W'(FLUSH_CYCLES);
            end
         end
         BR_FLUSH: begin
            // Counts down even while stalled; the squash window is fixed length.
            if (r_fcnt <= FC_W'(1)) begin
               w_state_next = BR_IDLE;
            end else begin
               w_fcnt_next = r_fcnt - FC_W'(1);
            end
         end
         default: w_state_next = BR_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= BR_IDLE;
         r_fcnt        <= '0;
         r_branch_cnt  <= '0;
         r_mispred_cnt <= '0;
      end else begin
         r_state <= w_state_next;
         r_fcnt  <= w_fcnt_next;
         if (w_resolve && (r_branch_cnt != '1)) begin
            r_branch_cnt <= r_branch_cnt + CNT_WIDTH'(1);
         end
         if (w_mispred && (r_mispred_cnt != '1)) begin
            r_mispred_cnt <= r_mispred_cnt + CNT_WIDTH'(1);
         end
      end
   end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: table of branches with hand-computed
// outcomes, plus stall, flush/reset and counter saturation sequences.
module tb_branch_resolve_unit;

   localparam int PCW = 32;
   localparam int FC  = 2;
   localparam int CW  = 4;

   logic           clk = 1'b0;
   logic           reset;
   logic           if_valid;
   logic [PCW-1:0] if_pc;
   logic           if_pred_taken;
   logic           stall;
   logic           ex_br_valid;
   logic           ex_br_taken;
   logic [PCW-1:0] ex_br_target;
   logic           update_en;
   logic [PCW-1:0] ex_pc;
   logic           actual_taken;
   logic           redirect_valid;
   logic [PCW-1:0] redirect_pc;
   logic           flush;
   logic [CW-1:0]  branch_cnt;
   logic [CW-1:0]  mispred_cnt;

   int total = 0;
   int bad   = 0;
   logic [CW-1:0] exp_bc;
   logic [CW-1:0] exp_mc;

   typedef struct {
      logic [PCW-1:0] pc;
      logic           pred;
      logic           taken;
      logic [PCW-1:0] target;
      logic           exp_mis;
      logic [PCW-1:0] exp_rpc;
   } vec_t;

   vec_t vecs[5];

   branch_resolve_unit #(.PC_WIDTH(PCW), .FLUSH_CYCLES(FC), .CNT_WIDTH(CW)) dut (
      .clk            (clk),
      .reset          (reset),
      .if_valid       (if_valid),
      .if_pc          (if_pc),
      .if_pred_taken  (if_pred_taken),
      .stall          (stall),
      .ex_br_valid    (ex_br_valid),
      .ex_br_taken    (ex_br_taken),
      .ex_br_target   (ex_br_target),
      .update_en      (update_en),
      .ex_pc          (ex_pc),
      .actual_taken   (actual_taken),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .flush          (flush),
      .branch_cnt     (branch_cnt),
      .mispred_cnt    (mispred_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_branch(input vec_t v);
      if_valid      = 1'b1;
      if_pc         = v.pc;
      if_pred_taken = v.pred;
      step();
      if_valid      = 1'b0;
      if_pc         = '0;
      if_pred_taken = 1'b0;
      step();
      ex_br_valid  = 1'b1;
      ex_br_taken  = v.taken;
      ex_br_target = v.target;
      #1;
      chk("update_en", update_en, 1);
      chk("ex_pc", ex_pc, v.pc);
      chk("actual_taken", actual_taken, v.taken);
      chk("redirect_valid", redirect_valid, v.exp_mis);
      if (v.exp_mis) chk("redirect_pc", redirect_pc, v.exp_rpc);
      chk("flush_resolve", flush, v.exp_mis);
      step();
      ex_br_valid = 1'b0;
      ex_br_taken = 1'b0;
      if (exp_bc != '1) exp_bc++;
      if (v.exp_mis && (exp_mc != '1)) exp_mc++;
      chk("branch_cnt", branch_cnt, exp_bc);
      chk("mispred_cnt", mispred_cnt, exp_mc);
      chk("update_after", update_en, 0);
      for (int k = 0; k < FC; k++) begin
         chk("flush_hold", flush, v.exp_mis);
         step();
      end
      chk("flush_end", flush, 0);
      $display("branch pc=%08h pred=%0b taken=%0b mis=%0b bcnt=%0d mcnt=%0d",
               v.pc, v.pred, v.taken, v.exp_mis, branch_cnt, mispred_cnt);
   endtask

   initial begin
      vecs[0] = '{32'h0000_0100, 1'b1, 1'b1, 32'h0000_0400, 1'b0, 32'h0000_0400};
      vecs[1] = '{32'h0000_0200, 1'b0, 1'b1, 32'h0000_0080, 1'b1, 32'h0000_0080};
      vecs[2] = '{32'hFFFF_FFFC, 1'b1, 1'b0, 32'h0000_1234, 1'b1, 32'h0000_0000};
      vecs[3] = '{32'h0000_0300, 1'b0, 1'b0, 32'h0000_0010, 1'b0, 32'h0000_0304};
      vecs[4] = '{32'h0000_1000, 1'b1, 1'b0, 32'h0000_2000, 1'b1, 32'h0000_1004};

      reset = 1'b1;
      if_valid = 1'b0; if_pc = '0; if_pred_taken = 1'b0; stall = 1'b0;
      ex_br_valid = 1'b0; ex_br_taken = 1'b0; ex_br_target = '0;
      exp_bc = '0; exp_mc = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_update_en", update_en, 0);
      chk("rst_redirect_valid", redirect_valid, 0);
      chk("rst_redirect_pc", redirect_pc, 0);
      chk("rst_flush", flush, 0);
      chk("rst_ex_pc", ex_pc, 0);
      chk("rst_branch_cnt", branch_cnt, 0);
      chk("rst_mispred_cnt", mispred_cnt, 0);
      @(negedge clk);
      reset = 1'b0;
      step();

      for (int i = 0; i < 5; i++) run_branch(vecs[i]);

      // Branch held in EX by a stall trains the predictor once, on release.
      if_valid = 1'b1; if_pc = 32'h0000_0500; if_pred_taken = 1'b1;
      step();
      if_valid = 1'b0; if_pc = '0; if_pred_taken = 1'b0;
      step();
      ex_br_valid = 1'b1; ex_br_taken = 1'b1; ex_br_target = 32'h0000_0900; stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("stall_update_en", update_en, 0);
         chk("stall_ex_pc", ex_pc, 32'h0000_0500);
         step();
      end
      chk("stall_branch_cnt", branch_cnt, exp_bc);
      stall = 1'b0;
      #1;
      chk("release_update_en", update_en, 1);
      chk("release_redirect", redirect_valid, 0);
      step();
      ex_br_valid = 1'b0;
      exp_bc++;
      #1;
      chk("release_branch_cnt", branch_cnt, exp_bc);
      chk("release_update_after", update_en, 0);
      $display("stall branch pc=00000500 bcnt=%0d", branch_cnt);

      // Branch valid during FLUSH is ignored; async reset mid-FLUSH clears all.
      if_valid = 1'b1; if_pc = 32'h0000_0600; if_pred_taken = 1'b0;
      step();
      if_valid = 1'b0; if_pc = '0;
      step();
      ex_br_valid = 1'b1; ex_br_taken = 1'b1; ex_br_target = 32'h0000_0040;
      #1;
      chk("f5_redirect_valid", redirect_valid, 1);
      chk("f5_redirect_pc", redirect_pc, 32'h0000_0040);
      step();
      exp_bc++; exp_mc++;
      #1;
      chk("f5_flush_update_en", update_en, 0);
      chk("f5_flush_redirect", redirect_valid, 0);
      chk("f5_flush", flush, 1);
      chk("f5_mispred_cnt", mispred_cnt, exp_mc);
      #2;
      reset = 1'b1;
      #1;
      chk("f5_rst_flush", flush, 0);
      chk("f5_rst_branch_cnt", branch_cnt, 0);
      chk("f5_rst_mispred_cnt", mispred_cnt, 0);
      chk("f5_rst_update_en", update_en, 0);
      ex_br_valid = 1'b0; ex_br_taken = 1'b0;
      exp_bc = '0; exp_mc = '0;
      @(negedge clk);
      reset = 1'b0;
      step();
      $display("flush/reset sequence flush=%0b bcnt=%0d mcnt=%0d", flush, branch_cnt, mispred_cnt);

      // Drive both counters to all-ones, then one more mispredict must not wrap.
      for (int i = 0; i < 16; i++) begin
         vec_t v;
         v = '{32'h0000_0700, 1'b0, 1'b1, 32'h0000_0A00, 1'b1, 32'h0000_0A00};
         run_branch(v);
      end
      chk("sat_branch_cnt", branch_cnt, 4'hF);
      chk("sat_mispred_cnt", mispred_cnt, 4'hF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
